// File: rtl/rob_pkg.sv
// Shared constants and the per-entry record for the reorder buffer.
package rob_pkg;

    localparam int unsigned ROB_ENTRIES = 16;
    localparam int unsigned ROB_TAG_W   = $clog2(ROB_ENTRIES);
    localparam int unsigned ROB_AREG_W  = 5;
    localparam int unsigned ROB_PREG_W  = 6;
    localparam int unsigned ROB_XLEN    = 64;

    typedef struct packed {
        logic                  valid;
        logic                  done;
        logic                  mispredict;
        logic [ROB_AREG_W-1:0] areg;
        logic [ROB_PREG_W-1:0] preg;
        logic [ROB_PREG_W-1:0] old_preg;
        logic [ROB_XLEN-1:0]   pc;
        logic [ROB_XLEN-1:0]   target;
    } rob_entry_t;

endpackage

// File: rtl/rob_ptr.sv
// Wrapping queue pointer with increment and synchronous clear.
module rob_ptr #(
    parameter int unsigned W = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] ptr_o
);

    logic [W-1:0] ptr_d, ptr_q;

    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = ptr_q + W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement queue: allocate at tail, complete by tag, retire from head,
// and squash everything when a mispredicted branch retires.
module reorder_buffer
    import rob_pkg::*;
#(
    parameter int unsigned ENTRIES = ROB_ENTRIES,
    parameter int unsigned TAG_W   = $clog2(ENTRIES),
    parameter int unsigned AREG_W  = ROB_AREG_W,
    parameter int unsigned PREG_W  = ROB_PREG_W,
    parameter int unsigned XLEN    = ROB_XLEN
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alloc_valid,
    input  logic [AREG_W-1:0] alloc_areg,
    input  logic [PREG_W-1:0] alloc_preg,
    input  logic [PREG_W-1:0] alloc_old_preg,
    input  logic [XLEN-1:0]   alloc_pc,
    output logic [TAG_W-1:0]  alloc_tag,
    input  logic              wb_valid,
    input  logic [TAG_W-1:0]  wb_tag,
    input  logic              wb_mispredict,
    input  logic [XLEN-1:0]   wb_target,
    output logic              rob_full,
    output logic              rob_empty,
    output logic              commit_valid,
    output logic [AREG_W-1:0] commit_areg,
    output logic [PREG_W-1:0] commit_preg,
    output logic [PREG_W-1:0] commit_old_preg,
    output logic [XLEN-1:0]   commit_pc,
    output logic              flush,
    output logic [XLEN-1:0]   flush_target
);

    localparam logic [TAG_W:0] FullCount = ENTRIES[TAG_W:0];

    rob_entry_t       entries_q [ENTRIES];
    rob_entry_t       entries_d [ENTRIES];
    logic [TAG_W:0]   count_d, count_q;
    logic [TAG_W-1:0] head, tail;
    rob_entry_t       head_entry;
    logic             alloc_ok;

    rob_ptr #(.W(TAG_W)) u_head_ptr (
        .clk_i  (clk),
        .rst_ni (reset),
        .clr_i  (flush),
        .inc_i  (commit_valid),
        .ptr_o  (head)
    );

    rob_ptr #(.W(TAG_W)) u_tail_ptr (
        .clk_i  (clk),
        .rst_ni (reset),
        .clr_i  (flush),
        .inc_i  (alloc_ok),
        .ptr_o  (tail)
    );

    assign head_entry      = entries_q[head];
    assign rob_full        = (count_q == FullCount);
    assign rob_empty       = (count_q == '0);
    assign commit_valid    = !rob_empty && head_entry.valid && head_entry.done;
    assign flush           = commit_valid && head_entry.mispredict;
    assign flush_target    = head_entry.target;
    assign commit_areg     = head_entry.areg;
    assign commit_preg     = head_entry.preg;
    assign commit_old_preg = head_entry.old_preg;
    assign commit_pc       = head_entry.pc;
    assign alloc_tag       = tail;
    assign alloc_ok        = alloc_valid && !rob_full && !flush;

    always_comb begin
        entries_d = entries_q;
        count_d   = count_q + {{TAG_W{1'b0}}, alloc_ok} - {{TAG_W{1'b0}}, commit_valid};
        if (flush) begin
            // Retiring branch squashes every younger entry, including this cycle's traffic.
            for (int i = 0; i < int'(ENTRIES); i++) begin
                entries_d[i].valid = 1'b0;
            end
            count_d = '0;
        end else begin
            if (wb_valid && entries_q[wb_tag].valid) begin
                entries_d[wb_tag].done       = 1'b1;
                entries_d[wb_tag].mispredict = wb_mispredict;
                entries_d[wb_tag].target     = wb_target;
            end
            if (commit_valid) begin
                entries_d[head].valid = 1'b0;
            end
            if (alloc_ok) begin
                entries_d[tail].valid      = 1'b1;
                entries_d[tail].done       = 1'b0;
                entries_d[tail].mispredict = 1'b0;
                entries_d[tail].areg       = alloc_areg;
                entries_d[tail].preg       = alloc_preg;
                entries_d[tail].old_preg   = alloc_old_preg;
                entries_d[tail].pc         = alloc_pc;
                entries_d[tail].target     = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
            for (int i = 0; i < int'(ENTRIES); i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            count_q   <= count_d;
            entries_q <= entries_d;
        end
    end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

In-order retirement queue for the out-of-order core. The frontend allocates one entry per renamed instruction. Execute units mark entries complete by tag. The head retires in program order, returning the superseded physical register to the free list. The block generates `rob_full`, which feeds the fetch and frontend stalls in hazard detection. It also generates the mispredict `flush`/`flush_target` pair, which drives the PC overwrite path.

## Interface
Parameters:
- `ENTRIES`, 16: queue depth; must be a power of two.
- `TAG_W`, `$clog2(ENTRIES)`: width of an entry tag.
- `AREG_W`, 5: architectural register index width.
- `PREG_W`, 6: physical register index width.
- `XLEN`, 64: PC width.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-low reset; the block is in reset while `reset`==0.
- `alloc_valid` in 1: frontend requests an entry this cycle.
- `alloc_areg` in AREG_W: destination architectural register.
- `alloc_preg` in PREG_W: newly mapped physical register.
- `alloc_old_preg` in PREG_W: previous mapping, freed at commit.
- `alloc_pc` in XLEN: PC of the instruction.
- `alloc_tag` out TAG_W: tag granted to this cycle's allocation (= tail).
- `wb_valid` in 1: an execute unit reports completion.
- `wb_tag` in TAG_W: tag of the completing entry.
- `wb_mispredict` in 1: the completing branch was mispredicted.
- `wb_target` in XLEN: correct target for a mispredicted branch.
- `rob_full` out 1: every entry is occupied.
- `rob_empty` out 1: no entry is occupied.
- `commit_valid` out 1: the head retires this cycle.
- `commit_areg`, `commit_preg`, `commit_old_preg`, `commit_pc` out: fields of the retiring head entry.
- `flush` out 1: retiring a mispredicted branch; squash everything.
- `flush_target` out XLEN: redirect PC, valid only when `flush`=1.

## Operation
- State:
  - `head`, `tail`: TAG_W pointers that wrap naturally at ENTRIES.
  - `count`: TAG_W+1 bits.
  - Per-entry fields: `valid`, `done`, `mispredict`, `target`, plus the allocation fields.
- Allocation:
  - Accepted when `alloc_valid && !rob_full && !flush`.
  - On acceptance, write the entry at `tail` with valid=1, done=0, mispredict=0, then increment `tail`.
  - A request while full or during a flush is dropped silently; the frontend stall must keep it held.
- Write-back:
  - When `wb_valid` and `valid[wb_tag]`, set `done`; also latch `mispredict` and `target`.
  - A write-back to an invalid entry is ignored.
- Commit:
  - `commit_valid = !rob_empty && valid[head] && done[head]`.
  - On commit, clear `valid[head]` and increment `head`.
  - At most one commit per cycle.
- Flush:
  - `flush = commit_valid && mispredict[head]`, with `flush_target = target[head]`.
  - The branch itself commits in the flush cycle.
  - At that edge all `valid` bits clear and `head`=`tail`=`count`=0. Any allocation or write-back in the same cycle is discarded.
- Count update:
  - `count += accepted_alloc - commit`; a simultaneous allocation and commit leaves `count` unchanged.
  - `rob_full = (count == ENTRIES)`.
  - `rob_empty = (count == 0)`.

## Timing
- Reset (`reset`==0 at an edge):
  - `head`=`tail`=`count`=0 and all `valid` bits clear.
  - Outputs: `rob_full`=0, `rob_empty`=1, `commit_valid`=0, `flush`=0, `alloc_tag`=0.
  - Reset in mid-operation discards all in-flight entries; there is no partial drain.
- Allocation timing: `alloc_tag` is combinational from `tail` and is valid in the cycle the request is presented.
- Latency:
  - A write-back at edge N makes the entry committable in cycle N+1 if it is at the head.
  - Minimum allocate-to-commit latency is 2 cycles (allocate at edge N, write-back presented in cycle N+1, commit in cycle N+2).
- Status outputs:
  - `rob_full`/`rob_empty` derive combinationally from registered `count`, so they change the cycle after the causing edge.
  - `rob_full` deasserts in the cycle after a commit from full.
- Simultaneous full and commit: the allocation is still dropped in that cycle, because `rob_full` is evaluated before the commit.
- Wrap-around: pointers roll from ENTRIES-1 to 0 with no bubble.
- `flush` and the commit fields are combinational from head state and assert in the same cycle.

## Structure
- `rob_pkg`:
  - `rob_entry_t` struct: valid, done, mispredict, areg, preg, old_preg, pc, target.
  - `ROB_ENTRIES` and `ROB_TAG_W` constants.
- Sub-module `rob_ptr`: wrapping pointer register with increment and synchronous clear. It is instantiated twice, once for `head` and once for `tail`.

## Test plan
- Reset, then 3 allocations with PCs 0x100/0x104/0x108 and no write-backs → tags 0,1,2; `rob_empty`=0; `commit_valid`=0.
- Write-back tags 2,0,1 in that order → commits occur in the order PC 0x100, 0x104, 0x108, one per cycle; `commit_old_preg` matches each allocation.
- 16 allocations without commits → `rob_full`=1 after the 16th. Next: a 17th allocation is dropped and `tail` is unchanged. Then write-back and commit tag 0 → `rob_full`=0 the next cycle and `alloc_tag` wraps to 0.
- Allocate 4 entries, write back tag 1 with mispredict and target 0x2000, then write back tag 0 → commit PC of tag 0. Next cycle: commit tag 1 with `flush`=1 and `flush_target`=0x2000. Afterwards `rob_empty`=1 and `alloc_tag`=0.
- Write-back to a never-allocated tag 5 → no state change; `commit_valid` remains 0.
- `reset` pulled low for one cycle with 6 entries in flight → all outputs return to their reset values and the next allocation gets tag 0.
